// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding, load-use stall and flush; `ID_EX_STATS_EN adds stall/flush counters
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [DW-1:0] id_instr,
  input  logic [DW-1:0] id_rs_val,
  input  logic [DW-1:0] id_rt_val,
  input  logic          id_wr_en,
  input  logic [RW-1:0] id_wr_addr,
  input  logic          id_mem_rd,
  input  logic          flush,
  input  logic          exmem_wr_en,
  input  logic [RW-1:0] exmem_wr_addr,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_wr_en,
  input  logic [RW-1:0] memwb_wr_addr,
  input  logic [DW-1:0] memwb_data,
  output logic          stall,
  output logic          ex_valid,
  output logic [DW-1:0] ex_instr,
  output logic [DW-1:0] ex_regA,
  output logic [DW-1:0] ex_regB,
  output logic          ex_wr_en,
  output logic [RW-1:0] ex_wr_addr,
  output logic          ex_mem_rd
`ifdef ID_EX_STATS_EN
  ,
  output logic [15:0]   stall_cnt,
  output logic [15:0]   flush_cnt
`endif
);
  logic [DW-1:0] rs_q, rt_q;
  logic [RW-1:0] id_rs, id_rt, ex_rs, ex_rt;
  logic          wr_en_q, mem_rd_q, hazard, bubble;
  logic          cap_rs, cap_rt, fa_exmem, fa_memwb, fb_exmem, fb_memwb;
  assign id_rs = RW'(id_instr[25:21]);
  assign id_rt = RW'(id_instr[20:16]);
  assign ex_rs = RW'(ex_instr[25:21]);
  assign ex_rt = RW'(ex_instr[20:16]);
  assign hazard = ex_valid & mem_rd_q & (ex_wr_addr != '0) & id_valid
                & ((ex_wr_addr == id_rs) | (ex_wr_addr == id_rt));
  assign stall  = hazard & ~flush & ~rst;
  assign bubble = flush | hazard | ~id_valid;
  // a write-back landing this cycle would otherwise be missed by the stale register-file read
  assign cap_rs = memwb_wr_en & (memwb_wr_addr != '0) & (memwb_wr_addr == id_rs);
  assign cap_rt = memwb_wr_en & (memwb_wr_addr != '0) & (memwb_wr_addr == id_rt);
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      ex_valid   <= 1'b0;
      ex_instr   <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      wr_en_q    <= 1'b0;
      ex_wr_addr <= '0;
      mem_rd_q   <= 1'b0;
    end else begin
      ex_valid   <= 1'b1;
      ex_instr   <= id_instr;
      rs_q       <= cap_rs ? memwb_data : id_rs_val;
      rt_q       <= cap_rt ? memwb_data : id_rt_val;
      wr_en_q    <= id_wr_en;
      ex_wr_addr <= id_wr_addr;
      mem_rd_q   <= id_mem_rd;
    end
  end
  assign fa_exmem = exmem_wr_en & (exmem_wr_addr != '0) & (exmem_wr_addr == ex_rs);
  assign fa_memwb = memwb_wr_en & (memwb_wr_addr != '0) & (memwb_wr_addr == ex_rs);
  assign fb_exmem = exmem_wr_en & (exmem_wr_addr != '0) & (exmem_wr_addr == ex_rt);
  assign fb_memwb = memwb_wr_en & (memwb_wr_addr != '0) & (memwb_wr_addr == ex_rt);
  always_comb begin
    ex_regA = fa_exmem ? exmem_result : fa_memwb ? memwb_data : rs_q;
    ex_regB = fb_exmem ? exmem_result : fb_memwb ? memwb_data : rt_q;
  end
  assign ex_wr_en  = wr_en_q & ex_valid;
  assign ex_mem_rd = mem_rd_q & ex_valid;
`ifdef ID_EX_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (flush && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif
endmodule
